// File: rtl/dino_game_sequencer_if.sv
// Interface for the dino game sequencer: per-frame controls in, game values out.
interface dino_game_sequencer_if;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic [31:0] cacti_x;
  logic [3:0]  speed;
  logic [19:0] score;
  logic [19:0] high_score;
  logic [1:0]  state;
  logic        game_over;
  logic        cactus_passed;

  modport master (
    output frame_tick, start_btn, collision,
    input  cacti_x, speed, score, high_score, state, game_over, cactus_passed
  );

  modport slave (
    input  frame_tick, start_btn, collision,
    output cacti_x, speed, score, high_score, state, game_over, cactus_passed
  );
endinterface

// File: rtl/dino_game_sequencer.sv
// Game-level sequencer: attract, run, collision-hold and game-over phases;
// owns cactus position, scroll speed, BCD score and high score.
module dino_game_sequencer #(
  parameter int unsigned CACTI_START       = 550,
  parameter int unsigned CACTI_MIN         = 10,
  parameter int unsigned SPEED_INIT        = 1,
  parameter int unsigned SPEED_MAX         = 8,
  parameter int unsigned SPEED_STEP_FRAMES = 600,
  parameter int unsigned SCORE_DIV         = 6,
  parameter int unsigned HOLD_FRAMES       = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  dino_game_sequencer_if.slave bus
);

  localparam int unsigned SC_W = $clog2(SCORE_DIV);
  localparam int unsigned SP_W = $clog2(SPEED_STEP_FRAMES);
  localparam int unsigned HD_W = $clog2(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cacti_x_q, cacti_x_d;
  logic [3:0]  speed_q, speed_d;
  logic [19:0] score_q, score_d;
  logic [19:0] high_score_q, high_score_d;
  logic [SC_W-1:0] score_cnt_q, score_cnt_d;
  logic [SP_W-1:0] spd_cnt_q, spd_cnt_d;
  logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic        game_over_q, game_over_d;
  logic        passed_q, passed_d;
  logic        start_q, start_d;
  logic        start_edge;

  // Digit-wise BCD increment; 99999 saturates instead of wrapping to 00000.
  function automatic logic [19:0] bcd_inc(input logic [19:0] v);
    logic [19:0] r;
    logic        carry;
    logic [3:0]  dig;
    r     = v;
    carry = 1'b1;
    if (v != 20'h99999) begin
      for (int unsigned i = 0; i < 5; i++) begin
        dig = v[4*i +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = dig + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_edge   = bus.start_btn & ~start_q;
    start_d      = bus.start_btn;
    state_d      = state_q;
    cacti_x_d    = cacti_x_q;
    speed_d      = speed_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    score_cnt_d  = score_cnt_q;
    spd_cnt_d    = spd_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    passed_d     = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d     = RUN;
          cacti_x_d   = 32'(CACTI_START);
          speed_d     = 4'(SPEED_INIT);
          score_d     = '0;
          score_cnt_d = '0;
          spd_cnt_d   = '0;
          hold_cnt_d  = '0;
        end
      end
      RUN: begin
        // Collision outranks a coincident frame tick: the frame is not advanced.
        if (bus.collision) begin
          state_d = DYING;
          if (score_q > high_score_q) high_score_d = score_q;
        end else if (bus.frame_tick) begin
          if (cacti_x_q < 32'(CACTI_MIN) + 32'(speed_q)) begin
            cacti_x_d = 32'(CACTI_START);
            passed_d  = 1'b1;
          end else begin
            cacti_x_d = cacti_x_q - 32'(speed_q);
          end
          if (score_cnt_q == SC_W'(SCORE_DIV - 1)) begin
            score_cnt_d = '0;
            score_d     = bcd_inc(score_q);
          end else begin
            score_cnt_d = score_cnt_q + SC_W'(1);
          end
          if (spd_cnt_q == SP_W'(SPEED_STEP_FRAMES - 1)) begin
            spd_cnt_d = '0;
            speed_d   = (speed_q >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed_q + 4'd1;
          end else begin
            spd_cnt_d = spd_cnt_q + SP_W'(1);
          end
        end
      end
      DYING: begin
        if (bus.frame_tick) begin
          if (hold_cnt_q == HD_W'(HOLD_FRAMES - 1)) begin
            hold_cnt_d = '0;
            state_d    = OVER;
          end else begin
            hold_cnt_d = hold_cnt_q + HD_W'(1);
          end
        end
      end
      default: ;
    endcase

    game_over_d = (state_d == DYING) || (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cacti_x_q    <= 32'(CACTI_START);
      speed_q      <= 4'(SPEED_INIT);
      score_q      <= '0;
      high_score_q <= '0;
      score_cnt_q  <= '0;
      spd_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      game_over_q  <= 1'b0;
      passed_q     <= 1'b0;
      start_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cacti_x_q    <= cacti_x_d;
      speed_q      <= speed_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      score_cnt_q  <= score_cnt_d;
      spd_cnt_q    <= spd_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      game_over_q  <= game_over_d;
      passed_q     <= passed_d;
      start_q      <= start_d;
    end
  end

  assign bus.cacti_x       = cacti_x_q;
  assign bus.speed         = speed_q;
  assign bus.score         = score_q;
  assign bus.high_score    = high_score_q;
  assign bus.state         = state_q;
  assign bus.game_over     = game_over_q;
  assign bus.cactus_passed = passed_q;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Bench for dino_game_sequencer: vector table, directed corner sequences and
// randomized traffic checked against an integer-arithmetic game model.
module tb_dino_game_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dino_game_sequencer_if bus ();

  dino_game_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Game model: plain integers, score kept in decimal.
  int m_state, m_x, m_speed, m_score, m_high, m_sframes, m_pframes, m_hold;
  bit m_go, m_passed, m_prev_start;

  logic [19:0] f_score;
  logic [31:0] f_x;

  function automatic logic [19:0] int2bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [19:0] b);
    int r;
    r = 0;
    for (int i = 4; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit ft, input bit sb, input bit col);
    bit edge_s;
    if (rst) begin
      m_state = 0; m_x = 550; m_speed = 1; m_score = 0; m_high = 0;
      m_sframes = 0; m_pframes = 0; m_hold = 0;
      m_go = 0; m_passed = 0; m_prev_start = 1;
      return;
    end
    edge_s       = sb && !m_prev_start;
    m_prev_start = sb;
    m_passed     = 0;
    if (m_state == 0 || m_state == 3) begin
      if (edge_s) begin
        m_state = 1; m_x = 550; m_speed = 1; m_score = 0;
        m_sframes = 0; m_pframes = 0; m_hold = 0;
      end
    end else if (m_state == 1) begin
      if (col) begin
        m_state = 2;
        if (m_score > m_high) m_high = m_score;
      end else if (ft) begin
        if (m_x < 10 + m_speed) begin m_x = 550; m_passed = 1; end
        else m_x = m_x - m_speed;
        m_sframes++;
        if (m_sframes == 6) begin
          m_sframes = 0;
          if (m_score < 99999) m_score++;
        end
        m_pframes++;
        if (m_pframes == 600) begin
          m_pframes = 0;
          if (m_speed < 8) m_speed++;
        end
      end
    end else begin
      if (ft) begin
        m_hold++;
        if (m_hold == 60) begin m_hold = 0; m_state = 3; end
      end
    end
    m_go = (m_state >= 2);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state",         32'(bus.state),         32'(m_state));
    check("cacti_x",       bus.cacti_x,            32'(m_x));
    check("speed",         32'(bus.speed),         32'(m_speed));
    check("score",         32'(bus.score),         32'(int2bcd(m_score)));
    check("high_score",    32'(bus.high_score),    32'(int2bcd(m_high)));
    check("game_over",     32'(bus.game_over),     32'(m_go));
    check("cactus_passed", 32'(bus.cactus_passed), 32'(m_passed));
  endtask

  task automatic cycle(input bit rst, input bit ft, input bit sb, input bit col);
    @(negedge clk);
    reset          = rst;
    bus.frame_tick = ft;
    bus.start_btn  = sb;
    bus.collision  = col;
    model_step(rst, ft, sb, col);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic restart();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
  endtask

  // Preloads score/cacti_x through one idle RUN cycle so later arithmetic starts from them.
  task automatic preload(input logic [19:0] s, input logic [31:0] x);
    @(negedge clk);
    bus.frame_tick = 0;
    bus.collision  = 0;
    f_score = s;
    f_x     = x;
    force dut.score_q   = f_score;
    force dut.cacti_x_q = f_x;
    model_step(0, 0, bus.start_btn, 0);
    m_score = bcd2int(s);
    m_x     = int'(x);
    @(posedge clk);
    #1;
    release dut.score_q;
    release dut.cacti_x_q;
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
    end
  endtask

  typedef struct {
    bit rst, ft, sb, col;
    logic [1:0] exp_state;
    bit exp_go;
    string name;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit found;
    bus.frame_tick = 0;
    bus.start_btn  = 1;
    bus.collision  = 0;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "reset_held_btn"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "btn_held_no_start"};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "idle_tick_ignored"};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "btn_release"};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, "btn_press_start"};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, "run_tick"};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, "collision"};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, "start_in_dying"};

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].rst, tbl[i].ft, tbl[i].sb, tbl[i].col);
      check({tbl[i].name, "_state"}, 32'(bus.state), 32'(tbl[i].exp_state));
      check({tbl[i].name, "_go"},    32'(bus.game_over), 32'(tbl[i].exp_go));
    end

    // Start values, 12 ticks, then run the cactus down to the wrap point.
    restart();
    check("start_cacti", bus.cacti_x, 32'd550);
    check("start_speed", 32'(bus.speed), 32'd1);
    check("start_score", 32'(bus.score), 32'h0);
    ticks(12);
    check("cacti_12", bus.cacti_x, 32'd538);
    check("score_12", 32'(bus.score), 32'h2);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (bus.cacti_x == 32'd10) found = 1;
      else ticks(1);
    end
    check("reach_x10", 32'(found), 32'd1);
    cycle(0, 1, 1, 0);
    check("wrap_x", bus.cacti_x, 32'd550);
    check("wrap_pulse", 32'(bus.cactus_passed), 32'd1);
    cycle(0, 0, 1, 0);
    check("wrap_pulse_end", 32'(bus.cactus_passed), 32'd0);

    // Speed ramp and saturation.
    restart();
    ticks(600);
    check("speed_600", 32'(bus.speed), 32'd2);
    ticks(7 * 600);
    check("speed_max", 32'(bus.speed), 32'd8);
    ticks(600);
    check("speed_sat", 32'(bus.speed), 32'd8);

    // BCD carry chain and saturation.
    restart();
    preload(20'h00099, 32'd550);
    ticks(6);
    check("bcd_carry", 32'(bus.score), 32'h00100);
    restart();
    preload(20'h99999, 32'd550);
    ticks(6);
    check("bcd_sat", 32'(bus.score), 32'h99999);

    // Collision with coincident tick, hold period, restart, reset from OVER.
    restart();
    preload(20'h00042, 32'd300);
    cycle(0, 1, 1, 1);
    check("dying_state", 32'(bus.state), 32'd2);
    check("dying_go", 32'(bus.game_over), 32'd1);
    check("dying_x", bus.cacti_x, 32'd300);
    check("dying_high", 32'(bus.high_score), 32'h00042);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("dying_start_ign", 32'(bus.state), 32'd2);
    ticks(59);
    check("hold_59", 32'(bus.state), 32'd2);
    ticks(1);
    check("hold_60", 32'(bus.state), 32'd3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("over_restart", 32'(bus.state), 32'd1);
    check("over_restart_score", 32'(bus.score), 32'h0);
    check("over_keep_high", 32'(bus.high_score), 32'h00042);
    cycle(0, 0, 1, 1);
    ticks(60);
    check("over_again", 32'(bus.state), 32'd3);
    cycle(1, 0, 0, 0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_high", 32'(bus.high_score), 32'h0);
    check("rst_go", 32'(bus.game_over), 32'd0);

    // Randomized traffic against the model.
    begin
      bit sb;
      sb = 0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 39) == 0) sb = ~sb;
        cycle($urandom_range(0, 2999) == 0,
              $urandom_range(0, 2) == 0,
              sb,
              $urandom_range(0, 299) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
